// File: rtl/mono_sig_extract.sv
// Per-scan groove-centre extractor for one sig channel: captures the first valid
// pulse, normalises its centre to the scan period and emits one 16-bit sample.
module mono_sig_extract #(
  parameter int unsigned MIN_WIDTH = 4,
  parameter int unsigned CHANNEL   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync_start,
  input  logic        dir,
  input  logic [31:0] sig_time,
  input  logic        sig_rise,
  input  logic        sig_fall,
  input  logic [31:0] t_ltr,
  input  logic [31:0] t_rtl,
  output logic [15:0] out_pos,
  output logic        out_err,
  output logic        out_chan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] drop_cnt
);

  localparam int unsigned TW = 32;
  localparam int unsigned PW = 16;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] DIV_STEPS = CW'(PW);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_HIGH, S_CALC, S_DIVIDE, S_OUTPUT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_period, w_period_nxt;
  logic          r_dir_l, w_dir_l_nxt;
  logic [TW-1:0] r_rise_t, w_rise_t_nxt;
  logic [TW-1:0] r_fall_t, w_fall_t_nxt;
  logic [TW-1:0] r_rem, w_rem_nxt;
  logic [PW-1:0] r_quo, w_quo_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [PW-1:0] r_pos, w_pos_nxt;
  logic          r_err, w_err_nxt;
  logic          r_valid, w_valid_nxt;
  logic [PW-1:0] r_last_good, w_last_good_nxt;
  logic          r_busy, w_busy_nxt;
  logic [TW-1:0] r_pend_period, w_pend_period_nxt;
  logic          r_pend_dir, w_pend_dir_nxt;
  logic [PW-1:0] r_drop, w_drop_nxt;

  logic [TW-1:0] w_sync_period;
  logic [TW-1:0] w_width;
  logic          w_width_ok;
  logic [TW:0]   w_sum;
  logic [TW-1:0] w_centre;
  logic [TW-1:0] w_centre_clamped;
  logic [TW:0]   w_shift;
  logic          w_fits;
  logic [TW-1:0] w_rem_sub;
  logic [PW-1:0] w_pos_final;

  // Datapath helpers: period select, pulse width, centre clamp, divider step
  assign w_sync_period    = dir ? t_rtl : t_ltr;
  assign w_width          = sig_time - r_rise_t;
  assign w_width_ok       = (sig_time >= r_rise_t) && (w_width >= TW'(MIN_WIDTH));
  assign w_sum            = {1'b0, r_rise_t} + {1'b0, r_fall_t};
  assign w_centre         = TW'(w_sum >> 1);
  assign w_centre_clamped = (w_centre >= r_period) ? (r_period - TW'(1)) : w_centre;
  assign w_shift          = {r_rem, 1'b0};
  assign w_fits           = (w_shift >= {1'b0, r_period});
  assign w_rem_sub        = w_shift[TW-1:0] - r_period;
  assign w_pos_final      = r_dir_l ? (16'hFFFF - r_quo) : r_quo;

  assign out_pos   = r_pos;
  assign out_err   = r_err;
  assign out_valid = r_valid;
  assign drop_cnt  = r_drop;
  assign out_chan  = 1'(CHANNEL);

  // Next-state and datapath update
  always_comb begin
    w_state_nxt       = r_state;
    w_period_nxt      = r_period;
    w_dir_l_nxt       = r_dir_l;
    w_rise_t_nxt      = r_rise_t;
    w_fall_t_nxt      = r_fall_t;
    w_rem_nxt         = r_rem;
    w_quo_nxt         = r_quo;
    w_cnt_nxt         = r_cnt;
    w_pos_nxt         = r_pos;
    w_err_nxt         = r_err;
    w_valid_nxt       = r_valid;
    w_last_good_nxt   = r_last_good;
    w_busy_nxt        = r_busy;
    w_pend_period_nxt = r_pend_period;
    w_pend_dir_nxt    = r_pend_dir;
    w_drop_nxt        = r_drop;

    // A new scan arriving while busy is queued; an already-queued one is lost
    if (sync_start && (r_state == S_CALC || r_state == S_DIVIDE || r_state == S_OUTPUT)) begin
      if (r_busy && (r_drop != 16'hFFFF)) begin
        w_drop_nxt = r_drop + 16'd1;
      end
      w_pend_period_nxt = w_sync_period;
      w_pend_dir_nxt    = dir;
      w_busy_nxt        = 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        if (sync_start) begin
          w_period_nxt = w_sync_period;
          w_dir_l_nxt  = dir;
          w_state_nxt  = S_ARMED;
        end
      end
      S_ARMED, S_HIGH: begin
        if (sync_start) begin
          // Scan ended without a usable pulse: report error, queue the new scan
          w_valid_nxt       = 1'b1;
          w_err_nxt         = 1'b1;
          w_pos_nxt         = r_last_good;
          w_busy_nxt        = 1'b1;
          w_pend_period_nxt = w_sync_period;
          w_pend_dir_nxt    = dir;
          w_state_nxt       = S_OUTPUT;
        end else if (r_state == S_HIGH && sig_fall) begin
          if (w_width_ok) begin
            w_fall_t_nxt = sig_time;
            w_state_nxt  = S_CALC;
          end else begin
            w_state_nxt  = S_ARMED;
          end
        end else if (sig_rise) begin
          w_rise_t_nxt = sig_time;
          w_state_nxt  = S_HIGH;
        end
      end
      S_CALC: begin
        if (r_period == '0) begin
          w_valid_nxt = 1'b1;
          w_err_nxt   = 1'b1;
          w_pos_nxt   = r_last_good;
          w_state_nxt = S_OUTPUT;
        end else begin
          w_rem_nxt   = w_centre_clamped;
          w_quo_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (r_cnt != DIV_STEPS) begin
          w_rem_nxt = w_fits ? w_rem_sub : w_shift[TW-1:0];
          w_quo_nxt = {r_quo[PW-2:0], w_fits};
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_pos_nxt       = w_pos_final;
          w_last_good_nxt = w_pos_final;
          w_err_nxt       = 1'b0;
          w_valid_nxt     = 1'b1;
          w_state_nxt     = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (r_valid && out_ready) begin
          w_valid_nxt = 1'b0;
          if (w_busy_nxt) begin
            w_period_nxt = w_pend_period_nxt;
            w_dir_l_nxt  = w_pend_dir_nxt;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = S_ARMED;
          end else begin
            w_state_nxt  = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_period      <= '0;
      r_dir_l       <= 1'b0;
      r_rise_t      <= '0;
      r_fall_t      <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_cnt         <= '0;
      r_pos         <= '0;
      r_err         <= 1'b0;
      r_valid       <= 1'b0;
      r_last_good   <= '0;
      r_busy        <= 1'b0;
      r_pend_period <= '0;
      r_pend_dir    <= 1'b0;
      r_drop        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_period      <= w_period_nxt;
      r_dir_l       <= w_dir_l_nxt;
      r_rise_t      <= w_rise_t_nxt;
      r_fall_t      <= w_fall_t_nxt;
      r_rem         <= w_rem_nxt;
      r_quo         <= w_quo_nxt;
      r_cnt         <= w_cnt_nxt;
      r_pos         <= w_pos_nxt;
      r_err         <= w_err_nxt;
      r_valid       <= w_valid_nxt;
      r_last_good   <= w_last_good_nxt;
      r_busy        <= w_busy_nxt;
      r_pend_period <= w_pend_period_nxt;
      r_pend_dir    <= w_pend_dir_nxt;
      r_drop        <= w_drop_nxt;
    end
  end

endmodule

// File: tb/tb_mono_sig_extract.sv
// Scoreboard bench for mono_sig_extract: directed scans plus randomized scans
// checked against an arithmetic reference of the groove-centre normalisation.
module tb_mono_sig_extract;

  localparam int unsigned MINW = 4;

  logic        clk = 1'b0;
  logic        reset, sync_start, dir, sig_rise, sig_fall, out_ready;
  logic [31:0] sig_time, t_ltr, t_rtl;
  logic [15:0] out_pos, drop_cnt;
  logic        out_err, out_chan, out_valid;

  always #5 clk = ~clk;

  mono_sig_extract #(.MIN_WIDTH(MINW), .CHANNEL(0)) dut (
    .clk(clk), .reset(reset), .sync_start(sync_start), .dir(dir),
    .sig_time(sig_time), .sig_rise(sig_rise), .sig_fall(sig_fall),
    .t_ltr(t_ltr), .t_rtl(t_rtl), .out_pos(out_pos), .out_err(out_err),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [15:0] pos;
    logic        err;
    bit          chk_lat;
    int          fe;
  } exp_t;

  exp_t        q[$];
  int          vecs = 0;
  int          miss = 0;
  int          cyc = 0;
  int          ready_mode = 2;
  logic [15:0] m_last_good = '0;
  bit          missing_prev = 1'b0;
  bit          mon_active = 1'b0;
  logic [15:0] mon_pos;
  logic        mon_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: centre of the pulse as a fraction of the period, in 1/65536 units
  function automatic logic [15:0] ref_pos(longint unsigned r, longint unsigned f,
                                          longint unsigned per, bit d);
    longint unsigned c, qv;
    c = (r + f) / 2;
    if (c >= per) c = per - 1;
    qv = (c * 65536) / per;
    return d ? 16'(65535 - qv) : 16'(qv);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sync(bit d, logic [31:0] pl, logic [31:0] pr);
    dir = d; t_ltr = pl; t_rtl = pr; sync_start = 1'b1;
    tick();
    sync_start = 1'b0;
  endtask

  task automatic edge_pulse(bit is_rise, logic [31:0] t);
    sig_time = t;
    if (is_rise) sig_rise = 1'b1; else sig_fall = 1'b1;
    tick();
    sig_rise = 1'b0; sig_fall = 1'b0;
  endtask

  task automatic push_exp(logic [15:0] p, logic e, bit lat, int fe);
    exp_t x;
    x.pos = p; x.err = e; x.chk_lat = lat; x.fe = fe;
    q.push_back(x);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 64'(q.size()), 0);
      q.delete();
    end
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    if (!out_valid) check("valid_timeout", 64'(out_valid), 1);
  endtask

  task automatic check_reset_outs(string tag);
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 0);
    check({tag, "_pos"}, 64'(out_pos), 0);
    check({tag, "_err"}, 64'(out_err), 0);
    check({tag, "_drop"}, 64'(drop_cnt), 0);
    check({tag, "_chan"}, 64'(out_chan), 0);
    tick();
  endtask

  // Good pulse with known result; fall sampled on the edge after it is driven
  task automatic good_pulse(logic [31:0] r, logic [31:0] f, logic [15:0] p);
    int fe;
    edge_pulse(1'b1, r);
    fe = cyc + 1;
    push_exp(p, 1'b0, 1'b1, fe);
    m_last_good = p;
    edge_pulse(1'b0, f);
  endtask

  // Randomized scan; a scan without a pulse is closed by the next scan's sync
  task automatic run_scan();
    bit              d;
    longint unsigned per, lim, r, f, w;
    int              fe;
    logic [15:0]     p;
    d = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       per = 0;
      1:       per = longint'($urandom());
      default: per = longint'($urandom_range(100, 200000));
    endcase
    if (d) do_sync(d, $urandom(), 32'(per));
    else   do_sync(d, 32'(per), $urandom());
    if (missing_prev) begin
      push_exp(m_last_good, 1'b1, 1'b0, 0);
      missing_prev = 1'b0;
      wait_drain();
    end
    lim = (per == 0) ? 1000 : per + per / 4;
    if (lim > 64'h7FFF_0000) lim = 64'h7FFF_0000;
    repeat ($urandom_range(0, 3)) tick();
    if ($urandom_range(0, 3) == 0) edge_pulse(1'b0, $urandom_range(0, 1000));
    if ($urandom_range(0, 2) == 0) begin
      r = longint'($urandom_range(0, 32'(lim)));
      edge_pulse(1'b1, 32'(r));
      repeat ($urandom_range(0, 2)) tick();
      edge_pulse(1'b0, 32'(r + longint'($urandom_range(0, MINW - 1))));
    end
    if ($urandom_range(0, 3) == 0) begin
      r = longint'($urandom_range(100, 32'(lim) + 100));
      edge_pulse(1'b1, 32'(r));
      edge_pulse(1'b0, 32'(r - longint'($urandom_range(1, 50))));
    end
    if ($urandom_range(0, 4) != 0) begin
      if ($urandom_range(0, 2) == 0) edge_pulse(1'b1, $urandom_range(0, 1000));
      r = longint'($urandom_range(0, 32'(lim)));
      w = ($urandom_range(0, 3) == 0) ? MINW : longint'($urandom_range(MINW, 5000));
      f = r + w;
      edge_pulse(1'b1, 32'(r));
      repeat ($urandom_range(0, 2)) tick();
      fe = cyc + 1;
      if (per == 0) begin
        push_exp(m_last_good, 1'b1, 1'b0, 0);
      end else begin
        p = ref_pos(r, f, per, d);
        push_exp(p, 1'b0, 1'b1, fe);
        m_last_good = p;
      end
      edge_pulse(1'b0, 32'(f));
      wait_drain();
    end else begin
      missing_prev = 1'b1;
    end
  endtask

  // Ready generator
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compare each new sample, then require it held until accepted
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active = 1'b0;
      end else if (out_valid) begin
        if (!mon_active) begin
          if (q.size() == 0) begin
            check("unexpected_sample", 64'(out_pos), 64'hFFFF_FFFF);
          end else begin
            check("pos", 64'(out_pos), 64'(q[0].pos));
            check("err", 64'(out_err), 64'(q[0].err));
            check("chan", 64'(out_chan), 0);
            if (q[0].chk_lat) check("latency", 64'(cyc - q[0].fe), 18);
          end
          mon_pos = out_pos;
          mon_err = out_err;
          mon_active = 1'b1;
        end else begin
          check("hold_pos", 64'(out_pos), 64'(mon_pos));
          check("hold_err", 64'(out_err), 64'(mon_err));
        end
        if (out_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; sync_start = 1'b0; dir = 1'b0; sig_rise = 1'b0; sig_fall = 1'b0;
    sig_time = '0; t_ltr = '0; t_rtl = '0;
    repeat (3) tick();
    check_reset_outs("reset");
    reset = 1'b0;
    tick();

    // LTR basic
    ready_mode = 2;
    do_sync(1'b0, 32'd1000, 32'd777);
    tick();
    good_pulse(32'd400, 32'd500, 16'd29491);
    wait_drain();

    // RTL with a 7-cycle consumer stall
    ready_mode = 1;
    do_sync(1'b1, 32'd5, 32'd1000);
    good_pulse(32'd400, 32'd500, 16'd36044);
    wait_valid();
    repeat (7) tick();
    ready_mode = 2;
    wait_drain();

    // Glitch rejected, following pulse used
    do_sync(1'b0, 32'd1000, 32'd0);
    edge_pulse(1'b1, 32'd100);
    edge_pulse(1'b0, 32'd102);
    good_pulse(32'd600, 32'd700, 16'd42598);
    wait_drain();

    // Missing pulse: error sample closes the scan, next scan already armed
    do_sync(1'b0, 32'd1000, 32'd0);
    repeat (3) tick();
    push_exp(16'd42598, 1'b1, 1'b0, 0);
    do_sync(1'b0, 32'd1000, 32'd0);
    wait_drain();
    good_pulse(32'd200, 32'd300, 16'd16384);
    wait_drain();

    // sync_start and sig_fall together in HIGH: edge discarded
    do_sync(1'b0, 32'd1000, 32'd0);
    edge_pulse(1'b1, 32'd400);
    push_exp(16'd16384, 1'b1, 1'b0, 0);
    dir = 1'b0; t_ltr = 32'd1000; sync_start = 1'b1; sig_fall = 1'b1; sig_time = 32'd500;
    tick();
    sync_start = 1'b0; sig_fall = 1'b0;
    wait_drain();
    good_pulse(32'd0, 32'd100, 16'd3276);
    wait_drain();

    // Overrun: three syncs while stalled, newest queued scan wins
    ready_mode = 1;
    do_sync(1'b0, 32'd1000, 32'd0);
    good_pulse(32'd400, 32'd500, 16'd29491);
    wait_valid();
    do_sync(1'b0, 32'd1000, 32'd0);
    tick();
    do_sync(1'b1, 32'd0, 32'd300);
    tick();
    do_sync(1'b0, 32'd2000, 32'd0);
    @(negedge clk);
    check("drop_cnt", 64'(drop_cnt), 2);
    ready_mode = 2;
    wait_drain();
    good_pulse(32'd400, 32'd600, 16'd16384);
    wait_drain();

    // Zero period
    do_sync(1'b0, 32'd0, 32'd0);
    edge_pulse(1'b1, 32'd10);
    push_exp(16'd16384, 1'b1, 1'b0, 0);
    edge_pulse(1'b0, 32'd50);
    wait_drain();

    // Reset in the middle of a divide
    do_sync(1'b0, 32'd1000, 32'd0);
    edge_pulse(1'b1, 32'd400);
    edge_pulse(1'b0, 32'd500);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outs("mid_div_reset");
    m_last_good = '0;
    edge_pulse(1'b1, 32'd10);
    edge_pulse(1'b0, 32'd100);
    repeat (25) tick();
    do_sync(1'b0, 32'd1000, 32'd0);
    tick();
    push_exp(16'd0, 1'b1, 1'b0, 0);
    do_sync(1'b0, 32'd1000, 32'd0);
    wait_drain();
    good_pulse(32'd400, 32'd500, 16'd29491);
    wait_drain();

    // Randomized scans
    ready_mode = 0;
    for (int i = 0; i < 80; i++) run_scan();
    if (missing_prev) begin
      do_sync(1'b0, 32'd1000, 32'd0);
      push_exp(m_last_good, 1'b1, 1'b0, 0);
      missing_prev = 1'b0;
      wait_drain();
    end
    repeat (30) tick();
    check("queue_empty", 64'(q.size()), 0);
    check("final_drop", 64'(drop_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
